fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WD, default 8, width of FIFO read data and of the output stream.
REQ-002 r_clk  input  1  read-domain clock; all logic is on its rising edge.
REQ-003 r_reset  input  1  synchronous, active-high reset.
REQ-004 fifo_empty  input  1  FIFO empty flag, already in the r_clk domain.
REQ-005 fifo_rd_en  output  1  read enable to the FIFO; drives its r_enbl.
REQ-006 fifo_rdata  input  DATA_WD  FIFO read data, valid exactly 1 cycle after an accepted read.
REQ-007 out_valid  output  1  output stream word valid.
REQ-008 out_ready  input  1  downstream accepts the word.
REQ-009 out_data  output  DATA_WD  output stream word.
REQ-010 out_level  output  2  number of words held in the skid buffer (0..3).

Function
REQ-011 A FIFO read is accepted in a cycle when fifo_rd_en=1 and fifo_empty=0, and its word is captured from fifo_rdata on the next rising edge.
REQ-012 fifo_rd_en shall be 1 iff fifo_empty=0 and (cnt + inflight) < 3, with cnt = buffered words and inflight = 1 if a read was accepted last cycle.
REQ-013 fifo_rd_en shall have no combinational path from out_ready; it comes only from registers and fifo_empty.
REQ-014 The block shall hold a 3-entry in-order buffer; out_data = head entry; out_valid = (cnt != 0).
REQ-015 Pop = out_valid & out_ready; push = inflight; same-cycle push and pop leave cnt unchanged and preserve order.
REQ-016 out_data and out_valid shall stay stable while out_valid=1 and out_ready=0.
REQ-017 Buffer state: EMPTY (cnt=0), PARTIAL (cnt 1..2), FULL (cnt=3); push-only increments cnt, pop-only decrements it, push+pop holds it.
REQ-018 A push in FULL is impossible by construction (REQ-012); an assertion shall flag it.
REQ-019 Latency: first word visible on out_valid 2 cycles after fifo_empty falls (read issue, then capture); out_ready held high gives one word per cycle sustained.
REQ-020 Read and write indices are 2-bit modulo-3 counters and wrap 2 -> 0.
REQ-021 out_level shall equal cnt registered, not including inflight.

Reset
REQ-022 While r_reset=1: fifo_rd_en=0, out_valid=0, out_level=0, cnt=0, inflight=0, indices=0, out_data=0.
REQ-023 A reset asserted mid-operation discards buffered words, and any word returning from a read accepted in the cycle before reset shall not be captured.
REQ-024 The first read after reset release shall be issued no earlier than the first cycle with r_reset=0.

Configuration
REQ-025 With macro FIFO_RD_STREAM_STATS_EN defined: an extra output word_count (input-less, 32 bits) counts pops, clears on reset, and wraps at 2^32 - 1 -> 0.
REQ-026 Without FIFO_RD_STREAM_STATS_EN: no word_count port and no counter logic.

Structure
REQ-027 Shared package fifo_rd_pkg holds BUF_DEPTH=3, the buffer-state enum (EMPTY, PARTIAL, FULL) and the index width constant.
REQ-028 One sub-module, fifo_rd_skid_buf, holds the 3-entry storage, indices and cnt; the top holds the issue/inflight logic and the optional stats counter.

Verification
REQ-029 FIFO preloaded with 0x11..0x18, out_ready=1 -> fifo_rd_en rises the cycle fifo_empty=0; out_data 0x11 appears 2 cycles later; 0x11..0x18 follow on consecutive cycles.
REQ-030 out_ready=0 with FIFO non-empty -> exactly 3 reads issued, out_level=3, fifo_rd_en=0; after out_ready=1, order 0x11,0x12,0x13,0x14 is preserved.
REQ-031 out_ready toggling every cycle with a random 200-word stream -> no loss, duplication or reorder; out_data stable whenever stalled.
REQ-032 fifo_empty rises while one read is inflight -> that word is still delivered; no further fifo_rd_en; out_valid drops after the buffer drains.
REQ-033 r_reset pulsed for 1 cycle with out_level=2 and one read inflight -> the next cycle shows out_valid=0, out_level=0, and the inflight word is not captured.
REQ-034 With FIFO_RD_STREAM_STATS_EN, 10 words popped -> word_count=10; after reset, word_count=0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared constants, buffer-state enum and modulo-3 index helpers for fifo_rd_stream.
package fifo_rd_pkg;
  localparam int BUF_DEPTH = 3;
  localparam int IDX_WD = 2;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} buf_state_t;
  function automatic logic [IDX_WD-1:0] idx_inc(input logic [IDX_WD-1:0] i);
    return (i == IDX_WD'(BUF_DEPTH - 1)) ? '0 : i + IDX_WD'(1);
  endfunction
  function automatic buf_state_t buf_state(input logic [1:0] cnt);
    return (cnt == 2'd0) ? EMPTY : (cnt == 2'(BUF_DEPTH)) ? FULL : PARTIAL;
  endfunction
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: 3-entry in-order buffer with modulo-3 indices and an occupancy count.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WD = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [DATA_WD-1:0] i_din,
  output logic [DATA_WD-1:0] o_dout,
  output logic [1:0]         o_cnt
);
  logic [DATA_WD-1:0] r_mem [BUF_DEPTH];
  logic [IDX_WD-1:0]  r_wr, r_rd;
  logic [1:0]         r_cnt;
  buf_state_t         w_state;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= idx_inc(r_wr);
      end
      if (i_pop) r_rd <= idx_inc(r_rd);
      r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
    end
  end
  assign w_state = buf_state(r_cnt);
  assign o_dout  = r_mem[r_rd];
  assign o_cnt   = r_cnt;
  // The issue logic never lets a word arrive when all three slots are taken.
  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst) i_push |-> w_state != FULL);
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a FIFO read port (1-cycle read latency) into a valid/ready stream.
// Optional macro FIFO_RD_STREAM_STATS_EN adds a 32-bit word_count of popped words.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WD = 8
) (
  input  logic               r_clk,
  input  logic               r_reset,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [DATA_WD-1:0] fifo_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_WD-1:0] out_data,
  output logic [1:0]         out_level
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]        word_count
`endif
);
  logic               r_inflight;
  logic [1:0]         w_cnt;
  logic [DATA_WD-1:0] w_head;
  logic               w_pop;
  // Reserve a slot for every outstanding read so the buffer can never overflow.
  assign fifo_rd_en = !r_reset && !fifo_empty && (({1'b0, w_cnt} + {2'b0, r_inflight}) < 3'(BUF_DEPTH));
  assign out_valid  = !r_reset && (w_cnt != 2'd0);
  assign out_level  = r_reset ? '0 : w_cnt;
  assign out_data   = r_reset ? '0 : w_head;
  assign w_pop      = out_valid && out_ready;
  always_ff @(posedge r_clk) r_inflight <= r_reset ? 1'b0 : fifo_rd_en;
  fifo_rd_skid_buf #(.DATA_WD(DATA_WD)) u_buf (
    .i_clk (r_clk),
    .i_rst (r_reset),
    .i_push(r_inflight),
    .i_pop (w_pop),
    .i_din (fifo_rdata),
    .o_dout(w_head),
    .o_cnt (w_cnt)
  );
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] r_word_count;
  always_ff @(posedge r_clk) r_word_count <= r_reset ? '0 : r_word_count + 32'(w_pop);
  assign word_count = r_word_count;
`endif
endmodule
